// File: rtl/uart_cfg_sequencer.sv
// UART receive-path configuration sequencer.
// Validates host configuration requests, waits for an idle Rx line, then
// applies baud/framing atomically: baud_ready low with the receiver in reset,
// a clock settle window, then release. Runs the same sequence with default
// settings after reset, without a cfg_done pulse.
module uart_cfg_sequencer #(
   parameter int IDLE_CYCLES   = 200,
   parameter int RST_HOLD      = 4,
   parameter int SETTLE_CYCLES = 16,
   parameter int TIMEOUT       = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_line,
   input  logic       cfg_wr,
   input  logic [2:0] cfg_baud,
   input  logic       cfg_parity,
   input  logic       cfg_parity_type,
   input  logic       cfg_stop_bits,
   input  logic [3:0] cfg_frame_length,
   output logic [2:0] baud,
   output logic       baud_ready,
   output logic       parity,
   output logic       parity_type,
   output logic       stop_bits,
   output logic [3:0] frame_length,
   output logic       uart_rst,
   output logic       cfg_busy,
   output logic       cfg_done,
   output logic       cfg_err
);

   localparam int PH_MAX = (RST_HOLD > SETTLE_CYCLES) ? RST_HOLD : SETTLE_CYCLES;
   localparam int IDLE_W = $clog2(IDLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT + 1);
   localparam int PH_W   = $clog2(PH_MAX + 1);

   typedef enum logic [1:0] {IDLE, WAIT_LINE, HOLD, SETTLE} state_t;

   state_t            state, state_n;
   logic              startup, startup_n;
   logic              err_pend, err_pend_n;
   logic [IDLE_W-1:0] idle_cnt, idle_cnt_n;
   logic [TO_W-1:0]   to_cnt, to_cnt_n;
   logic [PH_W-1:0]   ph_cnt, ph_cnt_n;

   // Shadow register: holds an accepted request until it can be applied.
   logic [2:0] sh_baud, sh_baud_n;
   logic       sh_parity, sh_parity_n;
   logic       sh_parity_type, sh_parity_type_n;
   logic       sh_stop_bits, sh_stop_bits_n;
   logic [3:0] sh_frame_length, sh_frame_length_n;

   logic [2:0] baud_n;
   logic       parity_n, parity_type_n, stop_bits_n;
   logic [3:0] frame_length_n;
   logic       baud_ready_n, uart_rst_n, cfg_busy_n, cfg_done_n, cfg_err_n;

   logic req_valid, idle_hit, to_hit;

   assign req_valid = (cfg_baud <= 3'd5) && (cfg_frame_length >= 4'd5) &&
                      (cfg_frame_length <= 4'd9);
   assign idle_hit  = rx_line && (idle_cnt == IDLE_W'(IDLE_CYCLES - 1));
   assign to_hit    = (to_cnt == TO_W'(TIMEOUT - 1));

   // Next-state, counter and output computation for the sequencer.
   always_comb begin
      state_n           = state;
      startup_n         = startup;
      err_pend_n        = 1'b0;
      idle_cnt_n        = idle_cnt;
      to_cnt_n          = to_cnt;
      ph_cnt_n          = ph_cnt;
      sh_baud_n         = sh_baud;
      sh_parity_n       = sh_parity;
      sh_parity_type_n  = sh_parity_type;
      sh_stop_bits_n    = sh_stop_bits;
      sh_frame_length_n = sh_frame_length;
      baud_n            = baud;
      parity_n          = parity;
      parity_type_n     = parity_type;
      stop_bits_n       = stop_bits;
      frame_length_n    = frame_length;
      baud_ready_n      = baud_ready;
      uart_rst_n        = uart_rst;
      cfg_busy_n        = cfg_busy;
      cfg_done_n        = 1'b0;
      // A rejection that collided with cfg_done is reported one cycle later.
      cfg_err_n         = err_pend;

      case (state)
         IDLE: begin
            if (cfg_wr) begin
               if (req_valid) begin
                  sh_baud_n         = cfg_baud;
                  sh_parity_n       = cfg_parity;
                  sh_parity_type_n  = cfg_parity_type;
                  sh_stop_bits_n    = cfg_stop_bits;
                  sh_frame_length_n = cfg_frame_length;
                  idle_cnt_n        = '0;
                  to_cnt_n          = '0;
                  cfg_busy_n        = 1'b1;
                  state_n           = WAIT_LINE;
               end else begin
                  cfg_err_n = 1'b1;
               end
            end
         end

         WAIT_LINE: begin
            if (cfg_wr) cfg_err_n = 1'b1;
            if (idle_hit) begin
               baud_n         = sh_baud;
               parity_n       = sh_parity;
               parity_type_n  = sh_parity_type;
               stop_bits_n    = sh_stop_bits;
               frame_length_n = sh_frame_length;
               baud_ready_n   = 1'b0;
               uart_rst_n     = 1'b1;
               ph_cnt_n       = '0;
               state_n        = HOLD;
            end else if (to_hit) begin
               cfg_err_n  = 1'b1;
               cfg_busy_n = 1'b0;
               state_n    = IDLE;
            end else begin
               if (!rx_line)
                  idle_cnt_n = '0;
               else if (idle_cnt != IDLE_W'(IDLE_CYCLES))
                  idle_cnt_n = idle_cnt + IDLE_W'(1);
               if (to_cnt != TO_W'(TIMEOUT))
                  to_cnt_n = to_cnt + TO_W'(1);
            end
         end

         HOLD: begin
            if (cfg_wr) cfg_err_n = 1'b1;
            if (ph_cnt == PH_W'(RST_HOLD - 1)) begin
               baud_ready_n = 1'b1;
               ph_cnt_n     = '0;
               state_n      = SETTLE;
            end else if (ph_cnt != PH_W'(PH_MAX)) begin
               ph_cnt_n = ph_cnt + PH_W'(1);
            end
         end

         SETTLE: begin
            if (ph_cnt == PH_W'(SETTLE_CYCLES - 1)) begin
               uart_rst_n = 1'b0;
               cfg_busy_n = 1'b0;
               cfg_done_n = !startup;
               startup_n  = 1'b0;
               state_n    = IDLE;
               if (cfg_wr) begin
                  if (startup) cfg_err_n  = 1'b1;
                  else         err_pend_n = 1'b1;
               end
            end else begin
               if (cfg_wr) cfg_err_n = 1'b1;
               if (ph_cnt != PH_W'(PH_MAX))
                  ph_cnt_n = ph_cnt + PH_W'(1);
            end
         end

         default: state_n = IDLE;
      endcase
   end

   // State, counter, shadow and output registers; reset starts bring-up.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= HOLD;
         startup         <= 1'b1;
         err_pend        <= 1'b0;
         idle_cnt        <= '0;
         to_cnt          <= '0;
         ph_cnt          <= '0;
         sh_baud         <= 3'd2;
         sh_parity       <= 1'b1;
         sh_parity_type  <= 1'b0;
         sh_stop_bits    <= 1'b0;
         sh_frame_length <= 4'd8;
         baud            <= 3'd2;
         parity          <= 1'b1;
         parity_type     <= 1'b0;
         stop_bits       <= 1'b0;
         frame_length    <= 4'd8;
         baud_ready      <= 1'b0;
         uart_rst        <= 1'b1;
         cfg_busy        <= 1'b1;
         cfg_done        <= 1'b0;
         cfg_err         <= 1'b0;
      end else begin
         state           <= state_n;
         startup         <= startup_n;
         err_pend        <= err_pend_n;
         idle_cnt        <= idle_cnt_n;
         to_cnt          <= to_cnt_n;
         ph_cnt          <= ph_cnt_n;
         sh_baud         <= sh_baud_n;
         sh_parity       <= sh_parity_n;
         sh_parity_type  <= sh_parity_type_n;
         sh_stop_bits    <= sh_stop_bits_n;
         sh_frame_length <= sh_frame_length_n;
         baud            <= baud_n;
         parity          <= parity_n;
         parity_type     <= parity_type_n;
         stop_bits       <= stop_bits_n;
         frame_length    <= frame_length_n;
         baud_ready      <= baud_ready_n;
         uart_rst        <= uart_rst_n;
         cfg_busy        <= cfg_busy_n;
         cfg_done        <= cfg_done_n;
         cfg_err         <= cfg_err_n;
      end
   end

endmodule
